trace_tx: RTL
=============

TRACE_TX -- requirements
Module: trace_tx

Interface
REQ-001 Parameter DEPTH, default 4: record FIFO depth in records; power of two, 2..16.
REQ-002 Parameter PERIOD, default 16: periodic sample interval in cycles; 0 disables periodic samples.
REQ-003 Port clk_i, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst_i, input, 1: reset, synchronous and active-low.
REQ-005 Port start_i, input, 1: CPU run enable; capture and counting only while high.
REQ-006 Port pc_i, input, 32: current PC of the CPU.
REQ-007 Port stall_i, input, 1: load-use stall this cycle; already excludes jump/branch cycles.
REQ-008 Port flush_i, input, 1: IF/ID flush this cycle.
REQ-009 Port data_o, output, 32: trace word.
REQ-010 Port valid_o, output, 1: data_o holds a valid trace word.
REQ-011 Port ready_i, input, 1: consumer accepts data_o.
REQ-012 Port drop_o, output, 1: sticky flag; at least one record was lost.

Function
REQ-013 Counters: stall_cnt (16b) and flush_cnt (16b) each increment on any edge with start_i=1 and the respective input high. Both saturate at 16'hFFFF.
REQ-014 Counters: cyc_cnt (32b) increments every edge with start_i=1 and wraps modulo 2^32. per_cnt counts 0..PERIOD-1 and wraps.
REQ-015 Trigger: a record is captured on an edge with start_i=1 and at least one of stall_i=1, flush_i=1, or (PERIOD!=0 and per_cnt==PERIOD-1).
REQ-016 Record fields: pc_i, stall_i, flush_i, and the post-increment stall_cnt, flush_cnt and cyc_cnt of the capture edge, plus seq (8b). seq increments per captured record, including dropped records, and wraps at 255.
REQ-017 FIFO full: if the FIFO holds DEPTH records at the capture edge, the record is dropped. drop_cnt (8b, saturating) increments and drop_o is set. A record released on the same edge does not admit the new one.
REQ-018 Word 0 (HDR): [31:24]=8'hA5, [23:16]=seq, [15:8]=drop_cnt value at transmit time, [7:2]=0, [1]=flush, [0]=stall.
REQ-019 Word 1 (PC) = pc. Word 2 (CNT) = {stall_cnt, flush_cnt}.
REQ-020 FSM states: IDLE, HDR, PCW, CNT (and TSW, see REQ-031).
  - IDLE->HDR when the FIFO is non-empty.
  - Each state advances only on a transfer edge (valid_o=1 and ready_i=1).
  - The last word state pops the record and goes to HDR if another record remains, else IDLE.
REQ-021 Latency: a record captured at edge k into an empty FIFO with the FSM in IDLE presents HDR with valid_o=1 after edge k+1. Back-to-back records have no idle cycle between them.
REQ-022 Handshake: valid_o is 1 exactly in word states. data_o and valid_o stay stable until transfer. valid_o never depends combinationally on ready_i.
REQ-023 valid_o=0 implies data_o=0.
REQ-024 When start_i=0, counters and capture freeze, but queued records keep draining.
REQ-025 Transfer and capture may happen on the same edge; both take effect.

Reset
REQ-026 On an edge with rst_i=0, all of the following return to 0: stall_cnt, flush_cnt, cyc_cnt, per_cnt, seq, drop_cnt, drop_o, FIFO count/pointers, data_o, valid_o. The FSM returns to IDLE.
REQ-027 Reset mid-record abandons the partial record; the first post-reset word is a fresh HDR with seq=0.
REQ-028 Capture and transfer are ignored on a reset edge.

Configuration
REQ-029 The macro TRACE_TIMESTAMP_EN controls the optional timestamp word.
REQ-030 Without TRACE_TIMESTAMP_EN: 3-word records (HDR, PCW, CNT); cyc_cnt is not stored in the FIFO.
REQ-031 With TRACE_TIMESTAMP_EN: state TSW follows CNT and sends Word 3 = cyc_cnt of the capture edge, making 4-word records. HDR bit[2]=1 marks the timestamped format.

Verification
REQ-032 Single stall: PERIOD=0, ready_i=1, stall_i=1 for one cycle at PC=20. Expected words: 32'hA5000001, 20, 32'h00010000; valid_o high exactly 3 cycles, starting the cycle after capture.
REQ-033 Backpressure: ready_i=0 for 5 cycles while HDR is pending. data_o must hold 32'hA5000001 unchanged; the sequence completes once ready_i=1.
REQ-034 Overflow: DEPTH=4, ready_i=0, flush_i=1 for 6 cycles. Expected: drop_o=1, drop_cnt=2, seq 0..3 queued; the first HDR after releasing ready_i is 32'hA5000202.
REQ-035 Periodic: PERIOD=16, idle CPU, 48 cycles. Expected: 3 records with seq 0,1,2 and CNT=0; with TRACE_TIMESTAMP_EN, timestamps 16, 32, 48.
REQ-036 Reset mid-record: rst_i=0 after the PCW transfer. Expected: valid_o=0 next cycle, no CNT word; the next event produces HDR with seq=0.
REQ-037 Saturation: force stall_cnt to 16'hFFFE, then 3 stalls. Expected CNT[31:16] sequence: FFFF, FFFF, FFFF.

Source files
------------

// File: rtl/trace_tx.sv
`default_nettype none
// ============================================================================
// Module      : trace_tx
// Description : CPU event tracer. Captures a record on stall, flush or
//               periodic-sample events, queues it in a small FIFO and streams
//               it out as HDR/PC/CNT words over a valid/ready port.
//               Optional macro TRACE_TIMESTAMP_EN adds a 4th timestamp word.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_tx #(
    parameter int DEPTH  = 4,
    parameter int PERIOD = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int   RW     = 106;
    localparam logic TS_BIT = 1'b1;
`else
    localparam int   RW     = 74;
    localparam logic TS_BIT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, HDR, PCW, CNT, TSW} state_t;

`ifdef TRACE_TIMESTAMP_EN
    localparam state_t LAST = TSW;
`else
    localparam state_t LAST = CNT;
`endif

    logic [15:0]   stall_cnt, flush_cnt, stall_nxt, flush_nxt;
    logic [31:0]   cyc_cnt, cyc_nxt;
    logic [PW-1:0] per_cnt;
    logic          per_hit;
    logic [7:0]    seq, drop_cnt;
    logic [AW:0]   count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [RW-1:0] mem [DEPTH];
    logic [RW-1:0] rec_in, head;
    logic          capture, full, push, pop, xfer, more;
    state_t        state, state_nxt;

    // Post-increment counter values of this edge; these are what a record stores
    assign stall_nxt = (start_i && stall_i && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
    assign flush_nxt = (start_i && flush_i && flush_cnt != 16'hFFFF) ? flush_cnt + 16'd1 : flush_cnt;
    assign cyc_nxt   = start_i ? cyc_cnt + 32'd1 : cyc_cnt;

    generate
        if (PERIOD == 0) begin : g_no_period
            assign per_hit = 1'b0;
        end else begin : g_period
            assign per_hit = (32'(per_cnt) == 32'(PERIOD - 1));
        end
    endgenerate

    assign capture = start_i & (stall_i | flush_i | per_hit);
    assign full    = (count == (AW+1)'(DEPTH));
    assign push    = capture & ~full;
    assign xfer    = valid_o & ready_i;
    assign pop     = xfer && (state == LAST);
    // Another record is available after this edge (remaining or newly pushed)
    assign more    = (count > (AW+1)'(1)) || push;

`ifdef TRACE_TIMESTAMP_EN
    assign rec_in = {cyc_nxt, seq, stall_nxt, flush_nxt, pc_i, flush_i, stall_i};
`else
    assign rec_in = {seq, stall_nxt, flush_nxt, pc_i, flush_i, stall_i};
`endif
    assign head = mem[rd_ptr];

    // Record storage; contents need no reset because count gates visibility
    always_ff @(posedge clk_i) begin
        if (rst_i && push) begin
            mem[wr_ptr] <= rec_in;
        end
    end

    // Event counters, sequence number, drop tracking and FIFO bookkeeping
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            cyc_cnt   <= '0;
            per_cnt   <= '0;
            seq       <= '0;
            drop_cnt  <= '0;
            drop_o    <= 1'b0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            stall_cnt <= stall_nxt;
            flush_cnt <= flush_nxt;
            cyc_cnt   <= cyc_nxt;
            if (start_i && PERIOD != 0) begin
                per_cnt <= per_hit ? '0 : per_cnt + PW'(1);
            end
            if (capture) begin
                seq <= seq + 8'd1;
            end
            if (capture && full) begin
                drop_o <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: one word per transfer, last word pops the record
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (count != '0) state_nxt = HDR;
            HDR:  if (xfer) state_nxt = PCW;
            PCW:  if (xfer) state_nxt = CNT;
`ifdef TRACE_TIMESTAMP_EN
            CNT:  if (xfer) state_nxt = TSW;
            TSW:  if (xfer) state_nxt = more ? HDR : IDLE;
`else
            CNT:  if (xfer) state_nxt = more ? HDR : IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output word mux; HDR shows the live drop count at transmit time
    always_comb begin
        data_o = '0;
        case (state)
            HDR: data_o = {8'hA5, head[73:66], drop_cnt, 5'b0, TS_BIT, head[1], head[0]};
            PCW: data_o = head[33:2];
            CNT: data_o = {head[65:50], head[49:34]};
`ifdef TRACE_TIMESTAMP_EN
            TSW: data_o = head[105:74];
`endif
            default: data_o = '0;
        endcase
    end

    assign valid_o = (state != IDLE);

endmodule
`default_nettype wire
